// File: rtl/prep4_stim_driver.sv
// prep4_stim_driver
// -----------------
// Stimulus driver for a PREP4 16-state machine in bring-up harnesses.
// On command it walks the attached machine along a fixed 25-step tour
// until it reaches the requested state. It then parks the machine there
// by applying that state's hold byte. Every cycle it checks the machine's
// output code against the state that the shadow tour position predicts.
// On any difference it resets the machine and starts again from tour
// index 0.
//
// Ports
//   CLK           clock
//   RST           synchronous, active-high reset
//   cmd_valid     target request valid
//   cmd_ready     high while idle and able to accept a target
//   cmd_target    requested state 0..15 (sampled on accept only)
//   rsp_valid     one-cycle completion pulse (no backpressure)
//   rsp_status    00 ok, 01 rejected, 10 aborted by mismatch
//   dut_i         registered input byte to the state machine
//   dut_o         output code returned by the state machine
//   dut_rst       registered reset pulse to the state machine
//   pos           current tour index 0..24
//   mismatch_cnt  saturating count of compare failures

module prep4_stim_driver (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_target,
    output logic       rsp_valid,
    output logic [1:0] rsp_status,
    output logic [7:0] dut_i,
    input  logic [7:0] dut_o,
    output logic       dut_rst,
    output logic [4:0] pos,
    output logic [7:0] mismatch_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MOVE   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_RESYNC = 2'd3;

    localparam logic [4:0] TOUR_LAST = 5'd24;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_REJECT = 2'b01;
    localparam logic [1:0] ST_ABORT  = 2'b10;

    // Machine state visited at each tour index.
    function automatic logic [3:0] tour_state(input logic [4:0] idx);
        logic [3:0] s;
        case (idx)
            5'd0:    s = 4'd0;
            5'd1:    s = 4'd2;
            5'd2:    s = 4'd3;
            5'd3:    s = 4'd5;
            5'd4:    s = 4'd7;
            5'd5:    s = 4'd4;
            5'd6:    s = 4'd6;
            5'd7:    s = 4'd8;
            5'd8:    s = 4'd11;
            5'd9:    s = 4'd15;
            5'd10:   s = 4'd13;
            5'd11:   s = 4'd12;
            5'd12:   s = 4'd0;
            5'd13:   s = 4'd1;
            5'd14:   s = 4'd3;
            5'd15:   s = 4'd5;
            5'd16:   s = 4'd7;
            5'd17:   s = 4'd4;
            5'd18:   s = 4'd6;
            5'd19:   s = 4'd9;
            5'd20:   s = 4'd11;
            5'd21:   s = 4'd15;
            5'd22:   s = 4'd14;
            5'd23:   s = 4'd10;
            5'd24:   s = 4'd1;
            default: s = 4'd0;
        endcase
        return s;
    endfunction

    // Byte that moves the machine from tour index idx to idx+1.
    function automatic logic [7:0] tour_step(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:    b = 8'h04;
            5'd1:    b = 8'h00;
            5'd2:    b = 8'h00;
            5'd3:    b = 8'h01;
            5'd4:    b = 8'hC0;
            5'd5:    b = 8'h00;
            5'd6:    b = 8'h40;
            5'd7:    b = 8'h10;
            5'd8:    b = 8'h40;
            5'd9:    b = 8'h82;
            5'd10:   b = 8'h02;
            5'd11:   b = 8'hFF;
            5'd12:   b = 8'h01;
            5'd13:   b = 8'h00;
            5'd14:   b = 8'h00;
            5'd15:   b = 8'h01;
            5'd16:   b = 8'hC0;
            5'd17:   b = 8'h00;
            5'd18:   b = 8'h80;
            5'd19:   b = 8'h01;
            5'd20:   b = 8'h40;
            5'd21:   b = 8'h80;
            5'd22:   b = 8'h80;
            5'd23:   b = 8'h00;
            5'd24:   b = 8'h03;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Output code the machine presents in each state.
    function automatic logic [7:0] state_code(input logic [3:0] s);
        logic [7:0] c;
        case (s)
            4'd0:    c = 8'h00;
            4'd1:    c = 8'h06;
            4'd2:    c = 8'h18;
            4'd3:    c = 8'h60;
            4'd4:    c = 8'h80;
            4'd5:    c = 8'hF0;
            4'd6:    c = 8'h1F;
            4'd7:    c = 8'h3F;
            4'd8:    c = 8'h7F;
            4'd9:    c = 8'hFF;
            4'd10:   c = 8'hFF;
            4'd11:   c = 8'hFF;
            4'd12:   c = 8'hFD;
            4'd13:   c = 8'hF7;
            4'd14:   c = 8'hDF;
            4'd15:   c = 8'h7F;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // States that can be parked in. The other states either have no
    // self-loop byte or are only passed through.
    function automatic logic is_holdable(input logic [3:0] s);
        logic h;
        case (s)
            4'd0, 4'd5, 4'd6, 4'd7, 4'd8,
            4'd9, 4'd12, 4'd14, 4'd15: h = 1'b1;
            default:                   h = 1'b0;
        endcase
        return h;
    endfunction

    // Byte that keeps the machine in a holdable state. Only st7 needs a
    // nonzero byte. A non-holdable state is never parked in, so its value
    // here is unused.
    function automatic logic [7:0] hold_byte(input logic [3:0] s);
        logic [7:0] b;
        case (s)
            4'd7:    b = 8'h40;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [1:0] fsm;
    logic [3:0] target;
    logic       inflight;
    logic [1:0] status_q;

    logic [4:0] pos_next;
    logic [3:0] cur_state;
    logic [3:0] next_state;
    logic       cmp_fail;
    logic       accept;

    assign pos_next   = (pos == TOUR_LAST) ? 5'd0 : pos + 5'd1;
    assign cur_state  = tour_state(pos);
    assign next_state = tour_state(pos_next);

    // While RST or dut_rst is high the machine is not yet known to be in
    // st0, so no compare is made in those cycles.
    assign cmp_fail = !RST && !dut_rst && (dut_o != state_code(cur_state));

    assign cmd_ready = (fsm == S_IDLE) && !RST;
    assign accept    = cmd_valid && cmd_ready;

    // The RESP cycle is also the arrival cycle. A compare failure in that
    // cycle overrides the pending ok/reject response, so rsp_valid depends
    // on the compare in the same cycle. In that case the command is
    // reported later as an abort from RESYNC.
    assign rsp_valid  = !RST && (((fsm == S_RESP) && !cmp_fail) ||
                                 ((fsm == S_RESYNC) && inflight));
    assign rsp_status = status_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            // Leave reset through RESYNC. This gives the machine its
            // dut_rst cycle and keeps cmd_ready low until reset is over.
            fsm          <= S_RESYNC;
            pos          <= 5'd0;
            dut_i        <= 8'h00;
            dut_rst      <= 1'b1;
            status_q     <= ST_OK;
            mismatch_cnt <= 8'h00;
            target       <= 4'd0;
            inflight     <= 1'b0;
        end else if (cmp_fail) begin
            fsm          <= S_RESYNC;
            pos          <= 5'd0;
            dut_i        <= 8'h00;
            dut_rst      <= 1'b1;
            status_q     <= ST_ABORT;
            // A command accepted in the failing cycle counts as in flight.
            inflight     <= (fsm != S_IDLE) || accept;
            if (mismatch_cnt != 8'hFF) begin
                mismatch_cnt <= mismatch_cnt + 8'd1;
            end
        end else begin
            dut_rst <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    dut_i <= hold_byte(cur_state);
                    if (accept) begin
                        target <= cmd_target;
                        if (!is_holdable(cmd_target)) begin
                            status_q <= ST_REJECT;
                            fsm      <= S_RESP;
                        end else if (cmd_target == cur_state) begin
                            status_q <= ST_OK;
                            fsm      <= S_RESP;
                        end else begin
                            dut_i <= tour_step(pos);
                            fsm   <= S_MOVE;
                        end
                    end
                end
                S_MOVE: begin
                    pos <= pos_next;
                    // Stop at the first tour index that reaches the target.
                    if (next_state == target) begin
                        dut_i    <= hold_byte(target);
                        status_q <= ST_OK;
                        fsm      <= S_RESP;
                    end else begin
                        dut_i <= tour_step(pos_next);
                    end
                end
                S_RESP: begin
                    fsm <= S_IDLE;
                end
                default: begin
                    fsm      <= S_IDLE;
                    inflight <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prep4_stim_driver.sv
// Testbench for prep4_stim_driver. A stand-in state machine follows the
// tour transitions and resets on dut_rst. A transaction-level model works
// out the per-cycle outputs from the tour tables. One compare process
// checks the DUT against that model every cycle.
module tb_prep4_stim_driver;

    logic       CLK = 1'b0;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_target;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic [7:0] dut_i;
    logic [7:0] dut_o;
    logic       dut_rst;
    logic [4:0] pos;
    logic [7:0] mismatch_cnt;

    always #5 CLK = ~CLK;

    prep4_stim_driver u_dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .dut_i(dut_i), .dut_o(dut_o), .dut_rst(dut_rst), .pos(pos),
        .mismatch_cnt(mismatch_cnt)
    );

    int tour_st [25] = '{0, 2, 3, 5, 7, 4, 6, 8, 11, 15, 13, 12, 0, 1, 3, 5, 7, 4, 6, 9, 11, 15, 14, 10, 1};
    int tour_by [25] = '{'h04, 'h00, 'h00, 'h01, 'hC0, 'h00, 'h40, 'h10, 'h40, 'h82, 'h02, 'hFF, 'h01,
                         'h00, 'h00, 'h01, 'hC0, 'h00, 'h80, 'h01, 'h40, 'h80, 'h80, 'h00, 'h03};
    int code_tab[16] = '{'h00, 'h06, 'h18, 'h60, 'h80, 'hF0, 'h1F, 'h3F,
                         'h7F, 'hFF, 'hFF, 'hFF, 'hFD, 'hF7, 'hDF, 'h7F};
    // -1 marks a state that cannot be held.
    int hold_tab[16] = '{0, -1, -1, -1, -1, 0, 0, 'h40, 0, 0, -1, -1, 0, -1, 0, 0};

    // Stand-in PREP4 machine: it only knows the tour edges and stays put
    // on any other byte.
    int   m_st = 0;
    logic corrupt = 1'b0;
    always @(posedge CLK) begin
        if (dut_rst === 1'b1) m_st <= 0;
        else begin
            for (int i = 0; i < 25; i++)
                if (tour_st[i] == m_st && tour_by[i] == int'(dut_i)) m_st <= tour_st[(i + 1) % 25];
        end
    end
    assign dut_o = 8'(code_tab[m_st]) ^ (corrupt ? 8'hA5 : 8'h00);

    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0, last_rsp_cyc = -1, last_rsp_st = -1;
    int mp = 0, mcnt = 0;
    bit chk_en = 0;
    int exp_pos, exp_di, exp_st;
    bit exp_rdy, exp_rv, exp_dr;
    int exp_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (rsp_valid === 1'b1) begin
            last_rsp_cyc = cyc;
            last_rsp_st  = int'(rsp_status);
        end
    end

    // Per-cycle compare against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("pos", pos, exp_pos);
            chk("dut_i", dut_i, exp_di);
            chk("cmd_ready", cmd_ready, exp_rdy);
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("dut_rst", dut_rst, exp_dr);
            chk("mismatch_cnt", mismatch_cnt, exp_cnt);
            if (exp_rv) chk("rsp_status", rsp_status, exp_st);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_exp(input int p, input int di, input bit rdy, input bit rv, input int st, input bit dr);
        exp_pos = p; exp_di = di; exp_rdy = rdy; exp_rv = rv; exp_st = st; exp_dr = dr; exp_cnt = mcnt;
    endtask

    task automatic set_idle();
        set_exp(mp, hold_tab[tour_st[mp]], 1, 0, 0, 0);
    endtask

    function automatic int steps_to(input int p, input int t);
        for (int k = 1; k <= 25; k++) if (tour_st[(p + k) % 25] == t) return k;
        return 0;
    endfunction

    function automatic int plan_len(input int p, input int t);
        if (hold_tab[t] < 0 || tour_st[p] == t) return 1;
        return steps_to(p, t) + 1;
    endfunction

    // One command. inj = cycle after accept (1-based) whose dut_o is
    // corrupted, 0 for none.
    task automatic do_cmd(input int t, input int inj);
        int k, st, last, p;
        tick(); cmd_valid = 1; cmd_target = 4'(t); set_idle(); acc_cyc = cyc;
        if (hold_tab[t] < 0) begin k = 0; st = 1; end
        else if (tour_st[mp] == t) begin k = 0; st = 0; end
        else begin k = steps_to(mp, t); st = 0; end
        last = k + 1;
        for (int c = 1; c <= last; c++) begin
            tick(); cmd_valid = 0; cmd_target = 4'($urandom); corrupt = (c == inj);
            if (c <= k) begin
                p = (mp + c - 1) % 25;
                set_exp(p, tour_by[p], 0, 0, st, 0);
            end else begin
                p = (mp + k) % 25;
                set_exp(p, hold_tab[tour_st[p]], 0, (c != inj), st, 0);
            end
            if (c == inj) break;
        end
        if (inj >= 1 && inj <= last) begin
            tick(); corrupt = 0;
            if (mcnt < 255) mcnt++;
            mp = 0;
            set_exp(0, 0, 0, 1, 2, 1);
        end else mp = (mp + k) % 25;
        tick(); corrupt = 0; set_idle();
    endtask

    task automatic idle_mismatch();
        tick(); corrupt = 1; set_idle();
        tick(); corrupt = 0;
        if (mcnt < 255) mcnt++;
        mp = 0;
        set_exp(0, 0, 0, 0, 0, 1);
        tick(); set_idle();
    endtask

    task automatic rst_mid(input int t, input int cr);
        int p;
        tick(); cmd_valid = 1; cmd_target = 4'(t); set_idle();
        for (int c = 1; c < cr; c++) begin
            tick(); cmd_valid = 0;
            p = (mp + c - 1) % 25;
            set_exp(p, tour_by[p], 0, 0, 0, 0);
        end
        tick(); RST = 1; chk_en = 0;
        tick(); mp = 0; mcnt = 0; set_exp(0, 0, 0, 0, 0, 1); chk_en = 1;
        chk("rst_mid_status", rsp_status, 2'b00);
        chk("rst_mid_cnt", mismatch_cnt, 8'h00);
        tick(); RST = 0;
        tick(); set_idle();
    endtask

    initial begin
        int t, l, inj, rsp_before;
        RST = 1; cmd_valid = 0; cmd_target = 0;
        tick(); tick();
        set_exp(0, 0, 0, 0, 0, 1); chk_en = 1;
        chk("reset_status", rsp_status, 2'b00);
        tick(); RST = 0;
        tick(); set_idle();

        do_cmd(9, 0);
        chk("pin_t9_pos", pos, 5'd19);
        chk("pin_t9_dut_i", dut_i, 8'h00);
        chk("pin_t9_latency", last_rsp_cyc - acc_cyc, 20);
        chk("pin_t9_status", last_rsp_st, 0);

        do_cmd(5, 0);
        chk("pin_t5_pos", pos, 5'd3);
        chk("pin_t5_latency", last_rsp_cyc - acc_cyc, 10);

        do_cmd(3, 0);
        chk("pin_rej3_latency", last_rsp_cyc - acc_cyc, 1);
        chk("pin_rej3_status", last_rsp_st, 1);
        do_cmd(2, 0);
        do_cmd(11, 0);
        chk("pin_rej_pos", pos, 5'd3);

        do_cmd(5, 0);
        chk("pin_same_latency", last_rsp_cyc - acc_cyc, 1);
        chk("pin_same_status", last_rsp_st, 0);

        do_cmd(12, 4);
        chk("pin_abort_cnt", mismatch_cnt, 8'd1);
        chk("pin_abort_pos", pos, 5'd0);
        chk("pin_abort_status", last_rsp_st, 2);
        do_cmd(12, 0);
        chk("pin_t12_pos", pos, 5'd11);

        rsp_before = last_rsp_cyc;
        idle_mismatch();
        chk("pin_idle_cnt", mismatch_cnt, 8'd2);
        chk("pin_idle_no_rsp", last_rsp_cyc, rsp_before);

        do_cmd(12, 0);
        rst_mid(9, 3);

        for (int n = 0; n < 60; n++) begin
            t = $urandom_range(0, 15);
            l = plan_len(mp, t);
            inj = ($urandom_range(0, 4) == 0) ? $urandom_range(1, l) : 0;
            do_cmd(t, inj);
            if ($urandom_range(0, 9) == 0) idle_mismatch();
        end

        repeat (260) idle_mismatch();
        chk("pin_sat_cnt", mismatch_cnt, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
